player_motion_ctl: RTL and testbench

- Frame-synchronous motion controller for the player sprite in the 800x600 VGA pipeline.
- Runs on the 40 MHz pixel clock.
- Samples left/right/jump command levels from the keyboard decoder and advances the player position exactly once per frame, on the vsync rising edge.
- Drives the registered xpos/ypos consumed by the player draw stage. A position update can never tear a frame mid-scan.

---
 rtl/player_motion_ctl.sv | 152 +++++++++++++++
 tb/tb_player_motion_ctl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/player_motion_ctl.sv
// Player sprite motion controller for the 800x600 VGA pipeline.
// Position advances once per frame on the vsync rising edge, so the draw
// stage never sees a position change in the middle of a scan.
module player_motion_ctl #(
   parameter int unsigned X_INIT   = 100,
   parameter int unsigned X_MIN    = 0,
   parameter int unsigned X_MAX    = 760,
   parameter int unsigned Y_GROUND = 500,
   parameter int unsigned STEP_X   = 4,
   parameter int unsigned JUMP_V   = 16,
   parameter int unsigned GRAVITY  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vsync,
   input  logic        start,
   input  logic        left,
   input  logic        right,
   input  logic        jump,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic        airborne,
   output logic        frame_tick
);

   typedef enum logic [1:0] {StIdle, StGround, StJump, StFall} state_e;

   localparam logic [11:0] XInit     = 12'(X_INIT);
   localparam logic [11:0] XMin      = 12'(X_MIN);
   localparam logic [11:0] XMax      = 12'(X_MAX);
   // Thresholds below which a full step would cross the clamp.
   localparam logic [11:0] XLeftLim  = 12'(X_MIN + STEP_X);
   localparam logic [11:0] XRightLim = 12'(X_MAX - STEP_X);
   localparam logic [11:0] XStep     = 12'(STEP_X);
   localparam logic [11:0] YGround   = 12'(Y_GROUND);
   localparam logic [5:0]  JumpV     = 6'(JUMP_V);
   localparam logic [5:0]  Grav      = 6'(GRAVITY);

   state_e      state_q, state_d;
   logic [11:0] xpos_q, xpos_d;
   logic [11:0] ypos_q, ypos_d;
   logic [5:0]  vel_q, vel_d;
   logic        vsync_q;
   logic        frame_tick_q, frame_tick_d;

   logic        tick;
   logic [11:0] x_move;
   logic [11:0] y_rise;
   logic [5:0]  vel_dec;
   logic [6:0]  vel_inc;
   logic [5:0]  vel_fall;
   logic [12:0] y_fall;
   logic        landing;

   assign tick = vsync & ~vsync_q;

   // Horizontal candidate position, clamped without ever wrapping.
   always_comb begin
      x_move = xpos_q;
      if (left && !right) begin
         x_move = (xpos_q < XLeftLim) ? XMin : xpos_q - XStep;
      end else if (right && !left) begin
         x_move = (xpos_q > XRightLim) ? XMax : xpos_q + XStep;
      end
   end

   // Vertical candidates for the rising and falling phases.
   always_comb begin
      y_rise   = (ypos_q < {6'd0, vel_q}) ? 12'd0 : ypos_q - {6'd0, vel_q};
      vel_dec  = vel_q - Grav;
      vel_inc  = {1'b0, vel_q} + {1'b0, Grav};
      vel_fall = (vel_inc > {1'b0, JumpV}) ? JumpV : vel_inc[5:0];
      y_fall   = {1'b0, ypos_q} + {7'd0, vel_fall};
      landing  = (y_fall >= {1'b0, YGround});
   end

   // Next-state logic: everything except leaving IDLE waits for a frame tick.
   always_comb begin
      state_d      = state_q;
      xpos_d       = xpos_q;
      ypos_d       = ypos_q;
      vel_d        = vel_q;
      frame_tick_d = tick && (state_q != StIdle);
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StGround;
            end
         end
         StGround: begin
            if (tick) begin
               xpos_d = x_move;
               if (jump) begin
                  state_d = StJump;
                  vel_d   = JumpV;
               end
            end
         end
         StJump: begin
            if (tick) begin
               xpos_d = x_move;
               ypos_d = y_rise;
               vel_d  = vel_dec;
               if (vel_dec == 6'd0) begin
                  state_d = StFall;
               end
            end
         end
         StFall: begin
            if (tick) begin
               xpos_d = x_move;
               if (landing) begin
                  ypos_d  = YGround;
                  vel_d   = 6'd0;
                  state_d = StGround;
               end else begin
                  ypos_d = y_fall[11:0];
                  vel_d  = vel_fall;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and position registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         xpos_q       <= XInit;
         ypos_q       <= YGround;
         vel_q        <= 6'd0;
         vsync_q      <= 1'b0;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         xpos_q       <= xpos_d;
         ypos_q       <= ypos_d;
         vel_q        <= vel_d;
         vsync_q      <= vsync;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign xpos       = xpos_q;
   assign ypos       = ypos_q;
   assign frame_tick = frame_tick_q;
   assign airborne   = (state_q == StJump) || (state_q == StFall);

endmodule

// File: tb/tb_player_motion_ctl.sv
// Directed bench for player_motion_ctl: one default instance plus two
// instances started near the left and right clamps, all on shared stimulus.
`timescale 1ns/1ps
module tb_player_motion_ctl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic vsync = 1'b0;
   logic start = 1'b0;
   logic left = 1'b0;
   logic right = 1'b0;
   logic jump = 1'b0;

   logic [11:0] xpos_m, ypos_m, xpos_lo, ypos_lo, xpos_hi, ypos_hi;
   logic        airb_m, airb_lo, airb_hi, ft_m, ft_lo, ft_hi;

   int checks = 0;
   int failures = 0;

   int up_y[16]   = '{484, 469, 455, 442, 430, 419, 409, 400,
                      392, 385, 379, 374, 370, 367, 365, 364};
   int down_y[16] = '{365, 367, 370, 374, 379, 385, 392, 400,
                      409, 419, 430, 442, 455, 469, 484, 500};

   always #5 clk = ~clk;

   player_motion_ctl dut (
      .clk(clk), .rst(rst), .vsync(vsync), .start(start), .left(left), .right(right),
      .jump(jump), .xpos(xpos_m), .ypos(ypos_m), .airborne(airb_m), .frame_tick(ft_m)
   );

   player_motion_ctl #(.X_INIT(2)) dut_lo (
      .clk(clk), .rst(rst), .vsync(vsync), .start(start), .left(left), .right(right),
      .jump(jump), .xpos(xpos_lo), .ypos(ypos_lo), .airborne(airb_lo), .frame_tick(ft_lo)
   );

   player_motion_ctl #(.X_INIT(758)) dut_hi (
      .clk(clk), .rst(rst), .vsync(vsync), .start(start), .left(left), .right(right),
      .jump(jump), .xpos(xpos_hi), .ypos(ypos_hi), .airborne(airb_hi), .frame_tick(ft_hi)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Raise vsync and return just after the edge that registers the update.
   task automatic frame_rise();
      @(negedge clk);
      vsync = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Hold vsync high for a number of clocks, then drop it.
   task automatic frame_fall(input int hold);
      repeat (hold) @(posedge clk);
      @(negedge clk);
      vsync = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset values.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_x", xpos_m, 100);
      chk("rst_y", ypos_m, 500);
      chk("rst_airb", airb_m, 0);
      chk("rst_ft", ft_m, 0);
      chk("rst_x_lo", xpos_lo, 2);
      chk("rst_x_hi", xpos_hi, 758);
      @(negedge clk);
      rst = 1'b0;

      // IDLE ignores ticks and keys.
      right = 1'b1;
      frame_rise();
      chk("idle_x", xpos_m, 100);
      chk("idle_airb", airb_m, 0);
      frame_fall(2);
      right = 1'b0;

      // Leave IDLE, then one frame with no keys.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      frame_rise();
      chk("f1_ft", ft_m, 1);
      chk("f1_x", xpos_m, 100);
      chk("f1_y", ypos_m, 500);
      chk("f1_airb", airb_m, 0);
      @(posedge clk);
      #1;
      chk("f1_ft_drop", ft_m, 0);
      frame_fall(3);

      // Right held for three frames.
      right = 1'b1;
      for (int i = 0; i < 3; i++) begin
         frame_rise();
         chk($sformatf("r%0d_x", i), xpos_m, 104 + 4 * i);
         chk($sformatf("r%0d_x_lo", i), xpos_lo, 6 + 4 * i);
         chk($sformatf("r%0d_x_hi", i), xpos_hi, 760);
         frame_fall(4);
         chk($sformatf("r%0d_x_hold", i), xpos_m, 104 + 4 * i);
      end

      // Left held for five frames; low instance clamps at 0.
      right = 1'b0;
      left = 1'b1;
      for (int i = 0; i < 5; i++) begin
         frame_rise();
         chk($sformatf("l%0d_x", i), xpos_m, 108 - 4 * i);
         chk($sformatf("l%0d_x_lo", i), xpos_lo, (i < 3) ? 10 - 4 * i : 0);
         frame_fall(2);
      end

      // Both directions cancel.
      right = 1'b1;
      frame_rise();
      chk("lr_x", xpos_m, 92);
      chk("lr_x_lo", xpos_lo, 0);
      chk("lr_x_hi", xpos_hi, 740);
      frame_fall(2);
      left = 1'b0;
      right = 1'b0;

      // Jump held throughout: launch, rise, fall, land.
      jump = 1'b1;
      frame_rise();
      chk("launch_airb", airb_m, 1);
      chk("launch_y", ypos_m, 500);
      frame_fall(2);
      for (int i = 0; i < 16; i++) begin
         frame_rise();
         chk($sformatf("up%0d_y", i), ypos_m, up_y[i]);
         frame_fall((i == 5) ? 1000 : 2);
         if (i == 5) chk("long_vsync_y", ypos_m, up_y[5]);
      end
      chk("apex_airb", airb_m, 1);
      for (int i = 0; i < 16; i++) begin
         frame_rise();
         chk($sformatf("dn%0d_y", i), ypos_m, down_y[i]);
         chk($sformatf("dn%0d_airb", i), airb_m, (i == 15) ? 0 : 1);
         frame_fall(2);
      end

      // Held jump re-launches on the tick after landing.
      frame_rise();
      chk("relaunch_airb", airb_m, 1);
      chk("relaunch_y", ypos_m, 500);
      frame_fall(2);
      for (int i = 0; i < 16; i++) begin
         frame_rise();
         frame_fall(2);
      end
      chk("apex2_y", ypos_m, 364);
      for (int i = 0; i < 8; i++) begin
         frame_rise();
         frame_fall(2);
      end
      chk("fall2_y", ypos_m, 400);
      chk("fall2_airb", airb_m, 1);

      // Asynchronous reset mid-fall, checked before any clock edge.
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_x", xpos_m, 100);
      chk("arst_y", ypos_m, 500);
      chk("arst_airb", airb_m, 0);
      @(negedge clk);
      rst = 1'b0;

      // Ticks ignored until start, even with keys held.
      right = 1'b1;
      frame_rise();
      chk("post_rst_x", xpos_m, 100);
      chk("post_rst_y", ypos_m, 500);
      chk("post_rst_airb", airb_m, 0);
      frame_fall(2);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      frame_rise();
      chk("restart_x", xpos_m, 104);
      chk("restart_y", ypos_m, 500);
      chk("restart_airb", airb_m, 1);
      frame_fall(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
